// File: rtl/shift_reg_pkg.sv
// rtl/shift_reg_pkg.sv - dir encodings and receiver state type shared by shift_deser
package shift_reg_pkg;

    localparam logic DIR_MSB_FIRST = 1'b0;
    localparam logic DIR_LSB_FIRST = 1'b1;

    typedef enum logic {
        COLLECT = 1'b0,
        DELIVER = 1'b1
    } state_t;

endpackage

// File: rtl/shift_deser.sv
// rtl/shift_deser.sv - serial-to-parallel receiver with one-entry valid/ready output register
// Optional trailing even-parity bit per word: SHIFT_DESER_PARITY_EN
module shift_deser
    import shift_reg_pkg::*;
#(
    parameter int width = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             s_in,
    input  logic             s_valid,
    input  logic             dir,
    output logic [width-1:0] p_out,
    output logic             p_valid,
    input  logic             p_ready,
    output logic             busy,
    output logic             overrun,
    output logic             parity_err
);

`ifdef SHIFT_DESER_PARITY_EN
    localparam int N = width + 1;
`else
    localparam int N = width;
`endif
    localparam int CW = $clog2(width + 2);

    logic [CW-1:0]    count;
    logic [width-1:0] sh;
    logic [width-1:0] sh_next;
    logic             dir_q;
    logic             dir_eff;
    logic             par_bad;
    logic             perr_q;
    logic             load;
    state_t           state;

    // dir is latched on the first bit and ignored for the rest of the word
    assign dir_eff = (count == '0) ? dir : dir_q;
    assign state   = (s_valid && count == CW'(N - 1)) ? DELIVER : COLLECT;
    assign load    = (state == DELIVER) && (!p_valid || p_ready);
    assign busy    = (count != '0);

    // The parity bit (if present) arrives after the data and is never shifted in
    always_comb begin
        sh_next = sh;
        if (s_valid && count < CW'(width)) begin
            if (dir_eff == DIR_MSB_FIRST) begin
                sh_next = {sh[width-2:0], s_in};
            end else begin
                sh_next = {s_in, sh[width-1:1]};
            end
        end
    end

`ifdef SHIFT_DESER_PARITY_EN
    assign par_bad = (^sh) ^ s_in;
`else
    assign par_bad = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh      <= '0;
            count   <= '0;
            dir_q   <= DIR_MSB_FIRST;
            p_out   <= '0;
            p_valid <= 1'b0;
            overrun <= 1'b0;
            perr_q  <= 1'b0;
        end else if (clear) begin
            count   <= '0;
            p_valid <= 1'b0;
            overrun <= 1'b0;
            perr_q  <= 1'b0;
        end else begin
            sh <= sh_next;
            if (s_valid) begin
                if (count == '0) begin
                    dir_q <= dir;
                end
                count <= (state == DELIVER) ? '0 : count + 1'b1;
            end
            if (state == DELIVER) begin
                if (load) begin
                    p_out   <= sh_next;
                    p_valid <= 1'b1;
                    perr_q  <= par_bad;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (p_valid && p_ready) begin
                p_valid <= 1'b0;
            end
        end
    end

    assign parity_err = perr_q;

endmodule

// File: tb/tb_shift_deser.sv
// tb/tb_shift_deser.sv - randomized and directed checks of shift_deser against a word-level model
module tb_shift_deser;

    localparam int W = 8;
`ifdef SHIFT_DESER_PARITY_EN
    localparam int N = W + 1;
`else
    localparam int N = W;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         clear = 1'b0;
    logic         s_in = 1'b0;
    logic         s_valid = 1'b0;
    logic         dir = 1'b0;
    logic         p_ready = 1'b0;
    logic [W-1:0] p_out;
    logic         p_valid;
    logic         busy;
    logic         overrun;
    logic         parity_err;

    int n_cmp = 0;
    int n_bad = 0;

    shift_deser #(.width(W)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear), .s_in(s_in), .s_valid(s_valid),
        .dir(dir), .p_out(p_out), .p_valid(p_valid), .p_ready(p_ready),
        .busy(busy), .overrun(overrun), .parity_err(parity_err)
    );

    always #5 clk = ~clk;

    // Word-level model: pending bits in a queue, word assembled once N bits exist
    logic         bits[$];
    logic         m_dir = 1'b0;
    logic [W-1:0] m_out = '0;
    logic         m_valid = 1'b0;
    logic         m_ovr = 1'b0;
    logic         m_perr = 1'b0;

    always @(posedge clk) begin
        logic         took;
        logic [W-1:0] w;
        logic         pbit;
        if (!rst_n) begin
            bits.delete();
            m_out = '0; m_valid = 1'b0; m_ovr = 1'b0; m_perr = 1'b0;
        end else if (clear) begin
            bits.delete();
            m_valid = 1'b0; m_ovr = 1'b0; m_perr = 1'b0;
        end else begin
            took = m_valid && p_ready;
            if (s_valid) begin
                if (bits.size() == 0) m_dir = dir;
                bits.push_back(s_in);
                if (bits.size() == N) begin
                    w = '0;
                    for (int i = 0; i < W; i++) begin
                        if (m_dir == 1'b0) w = w | (W'(bits[i]) << (W - 1 - i));
                        else               w = w | (W'(bits[i]) << i);
                    end
                    pbit = (N > W) ? bits[N-1] : 1'b0;
                    if (!m_valid || took) begin
                        m_out = w; m_valid = 1'b1;
                        m_perr = (N > W) ? ((^w) ^ pbit) : 1'b0;
                        took = 1'b0;
                    end else begin
                        m_ovr = 1'b1;
                    end
                    bits.delete();
                end
            end
            if (took) m_valid = 1'b0;
        end
    end

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    always @(posedge clk) begin
        #1;
        check("p_valid", W'(p_valid), W'(m_valid));
        check("busy", W'(busy), W'(bits.size() != 0));
        check("overrun", W'(overrun), W'(m_ovr));
        if (m_valid) begin
            check("p_out", p_out, m_out);
            check("parity_err", W'(parity_err), W'(m_perr));
        end
    end

    task automatic idle();
        @(negedge clk);
        s_valid = 1'b0;
        clear = 1'b0;
    endtask

    // Sends seq MSB-first in time; dir flips from bit index tog on; optional parity bit follows
    task automatic send_word(input logic [W-1:0] seq, input logic d, input int tog,
                             input logic badp, input logic chk0, input logic [W-1:0] exp0);
        for (int i = 0; i < N; i++) begin
            @(negedge clk);
            if (i == 0 && chk0) begin
                check("b2b_valid", W'(p_valid), W'(1));
                check("b2b_out", p_out, exp0);
            end
            clear = 1'b0;
            s_valid = 1'b1;
            s_in = (i < W) ? seq[W-1-i] : ((^seq) ^ badp);
            dir = (i >= tog) ? ~d : d;
        end
    endtask

    task automatic drain();
        @(negedge clk);
        s_valid = 1'b0;
        p_ready = 1'b1;
        @(negedge clk);
        p_ready = 1'b0;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("rst_p_out", p_out, 8'h00);
        check("rst_p_valid", W'(p_valid), 8'h00);
        check("rst_overrun", W'(overrun), 8'h00);
        rst_n = 1'b1;

        // 1: MSB-first
        send_word(8'hB2, 1'b0, 99, 1'b0, 1'b0, '0);
        idle();
        check("t1_out", p_out, 8'hB2);
        check("t1_valid", W'(p_valid), 8'h01);
        drain();

        // 2: LSB-first, then with a mid-word dir toggle
        send_word(8'hB2, 1'b1, 99, 1'b0, 1'b0, '0);
        idle();
        check("t2_out", p_out, 8'h4D);
        drain();
        send_word(8'hB2, 1'b1, 4, 1'b0, 1'b0, '0);
        idle();
        check("t2_tog_out", p_out, 8'h4D);
        drain();

        // 3: overrun while held
        send_word(8'hA5, 1'b0, 99, 1'b0, 1'b0, '0);
        send_word(8'h3C, 1'b0, 99, 1'b0, 1'b0, '0);
        idle();
        check("t3_out", p_out, 8'hA5);
        check("t3_ovr", W'(overrun), 8'h01);
        p_ready = 1'b1;
        @(negedge clk);
        p_ready = 1'b0;
        check("t3_valid_after", W'(p_valid), 8'h00);
        check("t3_ovr_sticky", W'(overrun), 8'h01);
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        check("t3_ovr_clr", W'(overrun), 8'h00);

        // 4: back-to-back with p_ready held
        p_ready = 1'b1;
        send_word(8'hA5, 1'b0, 99, 1'b0, 1'b0, '0);
        send_word(8'h3C, 1'b0, 99, 1'b0, 1'b1, 8'hA5);
        p_ready = 1'b0;
        idle();
        check("t4_out", p_out, 8'h3C);
        check("t4_ovr", W'(overrun), 8'h00);
        drain();

        // 5: clear mid-word, fresh word, then async reset mid-word
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            s_valid = 1'b1; s_in = 1'b1; dir = 1'b0;
        end
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        s_valid = 1'b0;
        check("t5_busy", W'(busy), 8'h00);
        send_word(8'hB2, 1'b0, 99, 1'b0, 1'b0, '0);
        idle();
        check("t5_out", p_out, 8'hB2);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            s_valid = 1'b1; s_in = 1'b1;
        end
        @(negedge clk);
        s_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("t5_rst_out", p_out, 8'h00);
        check("t5_rst_valid", W'(p_valid), 8'h00);
        check("t5_rst_busy", W'(busy), 8'h00);
        @(negedge clk);
        rst_n = 1'b1;

`ifdef SHIFT_DESER_PARITY_EN
        // 6: parity good then bad
        send_word(8'hB2, 1'b0, 99, 1'b0, 1'b0, '0);
        idle();
        check("t6_perr0", W'(parity_err), 8'h00);
        drain();
        send_word(8'hB2, 1'b0, 99, 1'b1, 1'b0, '0);
        idle();
        check("t6_perr1", W'(parity_err), 8'h01);
        check("t6_out", p_out, 8'hB2);
        drain();
`endif

        // Random traffic, including mid-word dir toggles and occasional clears
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            s_valid = ($urandom_range(0, 9) < 7);
            s_in = 1'($urandom);
            dir = 1'($urandom);
            p_ready = ($urandom_range(0, 1) == 1);
            clear = ($urandom_range(0, 63) == 0);
        end
        idle();
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
